stage_reader: RTL

//  Read-side engine for one FFT stage memory: on start, reads all N samples via the stage's two

---
 rtl/stage_reader_pkg.sv | 8 +
 rtl/stage_reader_if.sv | 30 +++
 rtl/stage_reader_addr_bitrev.sv | 11 +
 rtl/stage_reader.sv | 87 ++++++++
 4 files changed

// File: rtl/stage_reader_pkg.sv
// stage_reader_pkg: state encoding shared by the stage read engine
package stage_reader_pkg;
  typedef enum logic [1:0] {
    SR_IDLE  = 2'd0,
    SR_READ  = 2'd1,
    SR_DRAIN = 2'd2
  } sr_state_e;
endpackage

// File: rtl/stage_reader_if.sv
// stage_reader_if: stage read ports, metadata FIFO head and output stream of the stage reader
interface stage_reader_if #(
  parameter int LOG_N  = 3,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
);
  logic              start;
  logic [LOG_N-1:0]  out_addr0;
  logic [LOG_N-1:0]  out_addr1;
  logic [WIDTH-1:0]  in_data0;
  logic [WIDTH-1:0]  in_data1;
  logic [MWIDTH-1:0] m_data;
  logic              m_full;
  logic              m_read;
  logic              out_ready;
  logic              out_nd;
  logic [WIDTH-1:0]  out_data;
  logic [MWIDTH-1:0] out_m;
  logic              active;
  logic              done;
  logic              error;
  modport master (
    input  start, in_data0, in_data1, m_data, m_full, out_ready,
    output out_addr0, out_addr1, m_read, out_nd, out_data, out_m, active, done, error
  );
  modport slave (
    output start, in_data0, in_data1, m_data, m_full, out_ready,
    input  out_addr0, out_addr1, m_read, out_nd, out_data, out_m, active, done, error
  );
endinterface

// File: rtl/stage_reader_addr_bitrev.sv
// addr_bitrev: combinational bit reversal of a LOG_N-bit address
module addr_bitrev #(
  parameter int LOG_N = 3
) (
  input  logic [LOG_N-1:0] addr_i,
  output logic [LOG_N-1:0] addr_o
);
  for (genvar i = 0; i < LOG_N; i++) begin : g_rev
    assign addr_o[i] = addr_i[LOG_N-1-i];
  end
endmodule

// File: rtl/stage_reader.sv
// stage_reader: streams one FFT stage memory as serial samples with metadata; STAGE_READER_BITREV_EN selects bit-reversed read order
module stage_reader
  import stage_reader_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
) (
  input logic clk,
  input logic rst,
  stage_reader_if.master bus
);
  localparam logic [LOG_N-2:0] LAST_PAIR = (LOG_N-1)'(N/2-1);
  sr_state_e state_q, state_d;
  logic [LOG_N-2:0] k_q, k_cur;
  logic [LOG_N-1:0] addr0_q, addr1_q, addr0_d, addr1_d;
  logic [WIDTH-1:0] h0_q, h1_q;
  logic v0_q, v1_q, pend_q, settled_q, done_q, error_q;
  logic idle, tr, h_free, cap, start_ok, issue, last_tr;
  assign idle  = state_q == SR_IDLE;
  assign k_cur = idle ? '0 : k_q;
`ifdef STAGE_READER_BITREV_EN
  logic [LOG_N-1:0] rev;
  addr_bitrev #(.LOG_N(LOG_N)) u_bitrev (.addr_i({k_cur, 1'b0}), .addr_o(rev));
  assign addr0_d = rev;
  assign addr1_d = rev | LOG_N'(N/2);
`else
  assign addr0_d = {k_cur, 1'b0};
  assign addr1_d = {k_cur, 1'b1};
`endif
  // in_data keeps reflecting the held address, so a pending pair waits until both holding regs free up
  assign tr       = (v0_q | v1_q) & bus.out_ready;
  assign h_free   = ~(v0_q | v1_q) | ((v0_q ^ v1_q) & tr);
  assign cap      = pend_q & settled_q & h_free;
  assign start_ok = idle & bus.start;
  assign issue    = start_ok | ((state_q == SR_READ) & (~pend_q | cap));
  assign last_tr  = (state_q == SR_DRAIN) & ~pend_q & (v0_q ^ v1_q) & tr;
  assign state_d  = start_ok ? SR_READ
                  : ((state_q == SR_READ) && issue && (k_q == LAST_PAIR)) ? SR_DRAIN
                  : last_tr ? SR_IDLE
                  : state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= SR_IDLE;
      k_q       <= '0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      pend_q    <= 1'b0;
      settled_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        k_q     <= k_cur + (LOG_N-1)'(1);
        addr0_q <= addr0_d;
        addr1_q <= addr1_d;
      end
      pend_q    <= issue | (pend_q & ~cap);
      settled_q <= ~issue;
      if (cap) begin
        h0_q <= bus.in_data0;
        h1_q <= bus.in_data1;
        v0_q <= 1'b1;
        v1_q <= 1'b1;
      end else if (tr) begin
        v0_q <= 1'b0;
        v1_q <= v0_q & v1_q;
      end
      done_q  <= last_tr;
      error_q <= error_q | (tr & ~bus.m_full) | (bus.start & ~idle & ~last_tr);
    end
  assign bus.out_addr0 = addr0_q;
  assign bus.out_addr1 = addr1_q;
  assign bus.out_nd    = v0_q | v1_q;
  assign bus.out_data  = v0_q ? h0_q : h1_q;
  assign bus.out_m     = bus.out_nd ? bus.m_data : {MWIDTH{1'b0}};
  assign bus.m_read    = tr & bus.m_full;
  assign bus.active    = ~idle;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
endmodule
